// File: rtl/network_arbiter_if.sv
// Bundle of the requester-side and network-side signals around network_arbiter.
//   req/d0/d1        requester requests and cube states
//   valid/err/q      per-requester completion pulses and the registered result
//   busy             arbiter owns the network (GRANT, BUSY or DONE)
//   net_load/net_d   drive the network's level-sensitive load and its input state
//   net_valid/net_q  network completion pulse and result
// Modport slave is the arbiter; modport master is the surrounding environment.
interface network_arbiter_if #(
  parameter int unsigned DW = 120,
  parameter int unsigned QW = 4
) ();
  logic [1:0]    req;
  logic [DW-1:0] d0;
  logic [DW-1:0] d1;
  logic [1:0]    valid;
  logic [1:0]    err;
  logic [QW-1:0] q;
  logic          busy;
  logic          net_load;
  logic [DW-1:0] net_d;
  logic          net_valid;
  logic [QW-1:0] net_q;

  modport slave (
    input  req, d0, d1, net_valid, net_q,
    output valid, err, q, busy, net_load, net_d
  );

  modport master (
    output req, d0, d1, net_valid, net_q,
    input  valid, err, q, busy, net_load, net_d
  );
endinterface

// File: rtl/network_arbiter.sv
// Round-robin arbiter sharing one network inference instance between two cube datapaths.
// A granted requester's state is captured into net_d, net_load is held high until the
// network answers, and the 4-bit result comes back as a one-cycle valid pulse to the owner.
// Ports:
//   clk    single rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    network_arbiter_if.slave (req/d0/d1/valid/err/q/busy/net_load/net_d/net_valid/net_q)
// Optional feature: define NETWORK_ARB_TIMEOUT_EN to abort a job after TIMEOUT BUSY cycles
// without net_valid, pulsing err to the owner instead of valid. Without it err is tied 0.
module network_arbiter #(
  parameter int unsigned DW      = 120,
  parameter int unsigned QW      = 4,
  parameter int unsigned TIMEOUT = 200
) (
  input logic              clk,
  input logic              rst_n,
  network_arbiter_if.slave bus
);

  // The timeout counter is 8 bits wide.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("TIMEOUT must fit the 8-bit timeout counter");
  end

  typedef enum logic [1:0] {StIdle, StGrant, StBusy, StDone} state_e;

  state_e        state_q;
  logic          last_q;
  logic          owner_q;
  logic [1:0]    valid_q;
  logic [QW-1:0] q_q;
  logic [DW-1:0] net_d_q;
  logic          net_load_q;
  logic          busy_q;
  logic          winner;
  logic [1:0]    owner_oh;

`ifdef NETWORK_ARB_TIMEOUT_EN
  localparam logic [7:0] TimeoutCnt = TIMEOUT[7:0];
  logic [7:0] cnt_q;
  logic [1:0] err_q;
`endif

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    winner = 1'b0;
    case (bus.req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_q;
      default: winner = 1'b0;
    endcase
  end

  assign owner_oh = owner_q ? 2'b10 : 2'b01;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      valid_q    <= '0;
      q_q        <= '0;
      net_d_q    <= '0;
      net_load_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef NETWORK_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= '0;
`endif
    end else begin
      valid_q <= '0;
`ifdef NETWORK_ARB_TIMEOUT_EN
      err_q   <= '0;
`endif
      case (state_q)
        StIdle: begin
          if (|bus.req) begin
            owner_q <= winner;
            last_q  <= winner;
            busy_q  <= 1'b1;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          net_d_q    <= owner_q ? bus.d1 : bus.d0;
          net_load_q <= 1'b1;
          state_q    <= StBusy;
        end
        StBusy: begin
          // A result arriving on the timeout cycle still wins.
          if (bus.net_valid) begin
            q_q        <= bus.net_q;
            net_load_q <= 1'b0;
            valid_q    <= owner_oh;
            state_q    <= StDone;
`ifdef NETWORK_ARB_TIMEOUT_EN
            cnt_q      <= '0;
          end else if (cnt_q == TimeoutCnt) begin
            net_load_q <= 1'b0;
            err_q      <= owner_oh;
            state_q    <= StDone;
            cnt_q      <= '0;
          end else begin
            cnt_q      <= cnt_q + 8'd1;
`endif
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.valid    = valid_q;
  assign bus.q        = q_q;
  assign bus.net_d    = net_d_q;
  assign bus.net_load = net_load_q;
  assign bus.busy     = busy_q;
`ifdef NETWORK_ARB_TIMEOUT_EN
  assign bus.err      = err_q;
`else
  assign bus.err      = 2'b00;
`endif

endmodule

// File: tb/tb_network_arbiter.sv
// Bench for network_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a job-timeline model of the arbiter.
module tb_network_arbiter;
  localparam int unsigned DW  = 120;
  localparam int unsigned QW  = 4;
  localparam int unsigned TMO = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  network_arbiter_if #(.DW(DW), .QW(QW)) bus ();

  network_arbiter #(.DW(DW), .QW(QW), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- network behaviour ----------------
  int          lat = 5;      // net_valid in load cycle lat+1
  logic [3:0]  rsp = 4'h7;
  bit          drop = 1'b0;  // never answer
  bit          stray_en = 1'b0;
  logic [3:0]  stray_val = 4'h0;

  initial begin
    int lc;
    lc = 0;
    bus.net_valid = 1'b0;
    bus.net_q     = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lc = 0;
        bus.net_valid = 1'b0;
      end else begin
        lc = bus.net_load ? lc + 1 : 0;
        bus.net_valid = 1'b0;
        if (bus.net_load && lc == lat + 1 && !drop) begin
          bus.net_valid = 1'b1;
          bus.net_q     = rsp;
        end else if (!bus.net_load && stray_en) begin
          bus.net_valid = 1'b1;
          bus.net_q     = stray_val;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // One job at a time: started at edge m_e, answered (or timed out) at edge m_d.
  int          cyc = 0;
  bit          m_act = 1'b0;
  int          m_e = 0;
  int          m_d = -1;
  bit          m_own = 1'b0;
  bit          m_last = 1'b1;
  bit          m_err = 1'b0;
  logic [3:0]  m_q = '0;
  logic [DW-1:0] m_nd = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_act = 1'b0; m_last = 1'b1; m_q = '0; m_nd = '0; m_d = -1; m_err = 1'b0;
      end else begin
        cyc++;
        if (!m_act) begin
          if (bus.req != 2'b00) begin
            m_own  = (bus.req == 2'b11) ? !m_last : bus.req[1];
            m_last = m_own;
            m_act  = 1'b1;
            m_e    = cyc;
            m_d    = -1;
            m_err  = 1'b0;
          end
        end else if (m_d < 0) begin
          if (cyc == m_e + 1) begin
            m_nd = m_own ? bus.d1 : bus.d0;
          end else if (bus.net_valid) begin
            m_d = cyc;
            m_q = bus.net_q;
          end
`ifdef NETWORK_ARB_TIMEOUT_EN
          else if (cyc == m_e + int'(TMO) + 2) begin
            m_d   = cyc;
            m_err = 1'b1;
          end
`endif
        end else if (cyc == m_d + 1) begin
          m_act = 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [1:0] oh, e_valid, e_err;
    logic e_load;
    forever begin
      @(negedge clk);
      oh      = m_own ? 2'b10 : 2'b01;
      e_load  = m_act && m_d < 0 && cyc >= m_e + 1;
      e_valid = (m_act && m_d == cyc && !m_err) ? oh : 2'b00;
      e_err   = (m_act && m_d == cyc && m_err) ? oh : 2'b00;
      chk("busy",     128'(bus.busy),     128'(m_act));
      chk("net_load", 128'(bus.net_load), 128'(e_load));
      chk("valid",    128'(bus.valid),    128'(e_valid));
      chk("err",      128'(bus.err),      128'(e_err));
      chk("q",        128'(bus.q),        128'(m_q));
      chk("net_d",    128'(bus.net_d),    128'(m_nd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clk);
    bus.req = 2'b00;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
  endtask

  function automatic logic [DW-1:0] rand_state();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  initial begin
    int load_cnt, vcnt, nserved, rises, ecnt;
    int order [4];
    logic prev_load;
    logic [3:0] q_before;

    bus.req = 2'b00;
    bus.d0  = '0;
    bus.d1  = '0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_q",        128'(bus.q),        128'h0);
    chk("rst_net_d",    128'(bus.net_d),    128'h0);
    chk("rst_net_load", 128'(bus.net_load), 128'h0);
    chk("rst_valid",    128'(bus.valid),    128'h0);
    chk("rst_err",      128'(bus.err),      128'h0);
    chk("rst_busy",     128'(bus.busy),     128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request, 5-cycle network
    bus.d0 = 120'h1; bus.req = 2'b01; lat = 5; rsp = 4'h7;
    load_cnt = 0; vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.net_load) load_cnt++;
      if (bus.valid != 2'b00) begin
        vcnt++;
        chk("t1_valid", 128'(bus.valid), 128'h1);
        chk("t1_q",     128'(bus.q),     128'h7);
        chk("t1_net_d", 128'(bus.net_d), 128'h1);
        bus.req = 2'b00;
      end
    end
    chk("t1_load_cycles", 128'(load_cnt), 128'd6);
    chk("t1_valid_count", 128'(vcnt),     128'd1);

    // Simultaneous requests after reset
    do_reset();
    bus.d0 = rand_state(); bus.d1 = rand_state(); lat = 2; rsp = 4'h3;
    bus.req = 2'b11; nserved = 0; rises = 0; prev_load = 1'b0;
    for (int i = 0; i < 80 && nserved < 2; i++) begin
      @(negedge clk);
      if (bus.net_load && !prev_load) rises++;
      prev_load = bus.net_load;
      if (bus.valid != 2'b00) begin
        order[nserved] = int'(bus.valid[1]);
        nserved++;
        bus.req = bus.req & ~bus.valid;
      end
    end
    chk("t2_served",  128'(nserved),  128'd2);
    chk("t2_first",   128'(order[0]), 128'd0);
    chk("t2_second",  128'(order[1]), 128'd1);
    chk("t2_pulses",  128'(rises),    128'd2);

    // Fairness: both keep re-requesting
    do_reset();
    lat = 1; nserved = 0;
    bus.req = 2'b11;
    for (int i = 0; i < 200 && nserved < 4; i++) begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (bus.valid[r]) begin
          bus.req[r] = 1'b0;
          order[nserved] = r;
          nserved++;
        end else if (!bus.req[r]) begin
          bus.req[r] = 1'b1;
        end
      end
    end
    bus.req = 2'b00;
    chk("t3_served", 128'(nserved),  128'd4);
    chk("t3_job0",   128'(order[0]), 128'd0);
    chk("t3_job1",   128'(order[1]), 128'd1);
    chk("t3_job2",   128'(order[2]), 128'd0);
    chk("t3_job3",   128'(order[3]), 128'd1);
    repeat (30) @(negedge clk);

    // Stray net_valid in IDLE
    do_reset();
    stray_val = 4'hF; stray_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t4_q",     128'(bus.q),     128'h0);
      chk("t4_valid", 128'(bus.valid), 128'h0);
    end
    stray_en = 1'b0;

    // Asynchronous reset during BUSY
    lat = 20; bus.d1 = rand_state(); bus.req = 2'b10;
    for (int i = 0; i < 10 && !bus.net_load; i++) @(negedge clk);
    chk("t5_in_busy", 128'(bus.net_load), 128'h1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_load", 128'(bus.net_load), 128'h0);
    chk("t5_rst_busy", 128'(bus.busy),     128'h0);
    repeat (2) @(negedge clk);
    lat = 3; rsp = 4'hA;
    rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 30 && vcnt == 0; i++) begin
      @(negedge clk);
      if (bus.valid != 2'b00) begin
        vcnt++;
        chk("t5_valid", 128'(bus.valid), 128'h2);
        chk("t5_q",     128'(bus.q),     128'hA);
        bus.req = 2'b00;
      end
    end
    chk("t5_granted", 128'(vcnt), 128'd1);

`ifdef NETWORK_ARB_TIMEOUT_EN
    // Timeout: no answer
    do_reset();
    drop = 1'b1; bus.req = 2'b01; load_cnt = 0; ecnt = 0; q_before = bus.q;
    for (int i = 0; i < 40 && ecnt == 0; i++) begin
      @(negedge clk);
      if (bus.net_load) load_cnt++;
      chk("t6_no_valid", 128'(bus.valid), 128'h0);
      if (bus.err != 2'b00) begin
        ecnt++;
        chk("t6_err", 128'(bus.err), 128'h1);
        chk("t6_q",   128'(bus.q),   128'(q_before));
        bus.req = 2'b00;
      end
    end
    chk("t6_err_seen",   128'(ecnt),     128'd1);
    chk("t6_busy_cycles", 128'(load_cnt), 128'(TMO + 1));
    drop = 1'b0;

    // Result on the timeout cycle wins
    @(negedge clk);
    lat = int'(TMO); rsp = 4'h5; bus.req = 2'b01; vcnt = 0; ecnt = 0;
    for (int i = 0; i < 40 && vcnt == 0; i++) begin
      @(negedge clk);
      if (bus.err != 2'b00) ecnt++;
      if (bus.valid != 2'b00) begin
        vcnt++;
        chk("t7_valid", 128'(bus.valid), 128'h1);
        chk("t7_q",     128'(bus.q),     128'h5);
        bus.req = 2'b00;
      end
    end
    chk("t7_valid_seen", 128'(vcnt), 128'd1);
    chk("t7_no_err",     128'(ecnt), 128'd0);
`endif

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!bus.net_load) begin
        lat = int'($urandom_range(0, 12));
        rsp = 4'($urandom);
`ifdef NETWORK_ARB_TIMEOUT_EN
        drop = ($urandom_range(0, 7) == 0);
`endif
      end
      stray_en  = ($urandom_range(0, 3) == 0);
      stray_val = 4'($urandom);
      for (int r = 0; r < 2; r++) begin
        if (bus.valid[r] || bus.err[r]) begin
          bus.req[r] = 1'b0;
        end else if (!bus.req[r] && $urandom_range(0, 2) == 0) begin
          bus.req[r] = 1'b1;
          if (r == 0) bus.d0 = rand_state();
          else        bus.d1 = rand_state();
        end
      end
    end
    stray_en = 1'b0;
    drop     = 1'b0;
    lat      = 2;
    // Let any job in flight finish before closing.
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) if (bus.valid[r] || bus.err[r]) bus.req[r] = 1'b0;
    end
    bus.req = 2'b00;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/network_arbiter.md
# network_arbiter

Shares the single `network` inference instance between two cube datapaths. Each requester presents a 120-bit cube state and a request. The arbiter grants round-robin, captures the granted state, drives the network's level-sensitive `load`, and returns the 4-bit move to the owning requester with a one-cycle valid. It sits between the top-level controller's `cube` instances and `network`.

## Interface
- `DW`, 120: cube state width.
- `QW`, 4: network result width.
- `TIMEOUT`, 200: maximum BUSY cycles without `net_valid` (used only with `NETWORK_ARB_TIMEOUT_EN`); 8-bit counter.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  2  request per requester; held high until that requester's `valid` or `err`.
- `d0`, `d1`  in  DW  cube state of requester 0/1; sampled only on grant.
- `valid`  out  2  one-cycle pulse to the owning requester; `q` is valid in that cycle.
- `err`  out  2  one-cycle timeout pulse to the owner; tied 0 when the timeout feature is compiled out.
- `q`  out  QW  last network result, registered.
- `busy`  out  1  high while in GRANT, BUSY or DONE.
- `net_load`  out  1  to `network.load`.
- `net_d`  out  DW  to `network.d`, registered.
- `net_valid`  in  1  from `network.valid`, one-cycle pulse.
- `net_q`  in  QW  from `network.q`, valid with `net_valid`.

## Operation
- States: IDLE, GRANT, BUSY, DONE.
- IDLE: if any `req` bit is set, pick the owner and move to GRANT.
  - Only one bit set: that requester wins.
  - Both set: the requester other than `last` wins.
  - `last` updates to the winner.
- GRANT: `net_d` <= d of owner. Move to BUSY.
- BUSY: `net_load`=1. Stay until `net_valid`. Then `q` <= `net_q`, clear the timeout counter, and move to DONE.
- DONE: `valid[owner]`=1 (or `err[owner]`=1 after a timeout), `net_load`=0. Always move to IDLE next.
- `req` bits that drop while not granted are ignored; no request history is kept.
- Requests arriving during GRANT, BUSY or DONE wait. The owner is never preempted.
- Reset values:
  - state=IDLE, `last`=1, so requester 0 wins the first tie.
  - `q`=0, `net_d`=0, `net_load`=0, `valid`=0, `err`=0, `busy`=0, counter=0.
- Reset mid-transaction drops `net_load` immediately (asynchronous). No result is delivered.

## Timing
- `req` seen high at edge E (state IDLE):
  - GRANT during E..E+1.
  - `net_load`=1 from E+1.
- `net_valid` high in cycle k:
  - DONE in cycle k+1: `valid`/`q` visible, `net_load`=0.
  - IDLE in cycle k+2.
- Minimum turnaround, request to valid: network latency + 3 cycles.
- `net_load` is low for at least one cycle (DONE) between consecutive jobs. The network restarts on each `load` rising edge.
- The owner must deassert `req` on the edge that ends its `valid`/`err` cycle. Otherwise it is re-granted from IDLE, subject to round-robin.
- `net_valid` outside BUSY is ignored.

## Configuration
- `NETWORK_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter increments each BUSY cycle.
  - When it reaches `TIMEOUT` without `net_valid`: go to DONE, pulse `err[owner]` (not `valid`), leave `q` unchanged.
  - If `net_valid` arrives in the same cycle the count reaches `TIMEOUT`, the result wins: `valid` pulses, `err` does not.
- Undefined: no counter. BUSY waits indefinitely and `err` is constant 0.

## Test plan
- Single request: `req`=01, `d0`=120'h1, network returns `net_q`=4'h7 after 5 cycles -> `valid`=01 for one cycle with `q`=7. `net_load` high for exactly 6 cycles. `net_d`=1.
- Simultaneous requests after reset: `req`=11 -> requester 0 served first (`valid`=01), then requester 1 (`valid`=10). Two separate `net_load` pulses separated by at least one low cycle.
- Fairness: requester 0 re-requests immediately while `req[1]` is held -> grant order 0, 1, 0, 1 over four jobs.
- Stray `net_valid` in IDLE with `net_q`=4'hF -> `q` stays 0 and no `valid` pulses.
- Timeout (macro defined, `TIMEOUT`=10): no `net_valid` -> `err[owner]` pulses in BUSY cycle 11, `valid` stays 0, `q` unchanged. Variant: `net_valid` in that same cycle -> `valid` pulses, not `err`.
- Asynchronous reset asserted in BUSY -> `net_load`=0 and `busy`=0 immediately. After release, a request from requester 1 alone is granted normally.
